// File: rtl/otf_pkg.sv
// Shared definitions for the on-the-fly signed-digit converter.
//   state_t    : converter FSM states
//   D_POS/D_NEG/D_ZERO : {dp,dn} encodings of +1, -1 and 0 (11 also decodes to 0)
//   N_DEFAULT  : default number of signed digits per operand
package otf_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] D_POS  = 2'b10;
  localparam logic [1:0] D_NEG  = 2'b01;
  localparam logic [1:0] D_ZERO = 2'b00;

  localparam int N_DEFAULT = 16;

endpackage

// File: rtl/otf_digit_step.sv
// One step of the on-the-fly conversion recurrence (purely combinational).
// Ports:
//   i_q, i_qm  : current Q and QM = Q - 1 (W bits, two's complement)
//   i_dp, i_dn : signed digit rails, d = dp - dn
//   o_q, o_qm  : Q and QM after appending digit d
module otf_digit_step
  import otf_pkg::*;
#(
  parameter int W = 17
) (
  input  logic [W-1:0] i_q,
  input  logic [W-1:0] i_qm,
  input  logic         i_dp,
  input  logic         i_dn,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_qm
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] w_q2;
  logic [W-1:0] w_qm2;

  assign w_q2  = i_q << 1;
  assign w_qm2 = i_qm << 1;

  always_comb begin
    o_q  = w_q2;
    o_qm = w_qm2 | ONE;
    case ({i_dp, i_dn})
      D_POS: begin
        o_q  = w_q2 | ONE;
        o_qm = w_q2;
      end
      D_NEG: begin
        o_q  = w_qm2 | ONE;
        o_qm = w_qm2;
      end
      default: begin
        // D_ZERO and the redundant 11 encoding
        o_q  = w_q2;
        o_qm = w_qm2 | ONE;
      end
    endcase
  end

endmodule

// File: rtl/otf_converter.sv
// On-the-fly converter: MSD-first signed-digit stream -> two's-complement word.
// Ports:
//   clk, rst (async, active-high)
//   start      : pulse, (re)starts a conversion from any state
//   in_valid   : dp/dn carry a digit this cycle
//   dp, dn     : signed digit rails, d = dp - dn
//   in_ready   : digit accepted this cycle if in_valid (RUN only)
//   busy       : conversion in progress (RUN only)
//   res_valid  : one-cycle pulse, q holds a new result
//   q          : N+1 bit two's-complement result
//   zero       : result == 0 flag
// Build option: define OTF_ZERO_DETECT_EN to register the zero flag with q;
// otherwise zero is tied low.
module otf_converter
  import otf_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic       dp,
  input  logic       dn,
  output logic       in_ready,
  output logic       busy,
  output logic       res_valid,
  output logic [N:0] q,
  output logic       zero
);

  localparam int CW = $clog2(N + 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [N:0]    r_q_acc;
  logic [N:0]    r_qm_acc;
  logic [CW-1:0] r_cnt;
  logic [N:0]    r_q;
  logic          r_res_valid;
  logic [N:0]    w_q_next;
  logic [N:0]    w_qm_next;
  logic          w_accept;
  logic          w_last;

  assign w_last = (r_cnt == CW'(N - 1));

  otf_digit_step #(.W(N + 1)) u_step (
    .i_q  (r_q_acc),
    .i_qm (r_qm_acc),
    .i_dp (dp),
    .i_dn (dn),
    .o_q  (w_q_next),
    .o_qm (w_qm_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: w_state_next = S_IDLE;
      S_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        // a digit presented together with start belongs to no conversion
        w_accept = in_valid & ~start;
        if (w_accept && w_last) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (start) w_state_next = S_RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_acc     <= '0;
      r_qm_acc    <= '1;
      r_cnt       <= '0;
      r_q         <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      if (start) begin
        r_q_acc  <= '0;
        r_qm_acc <= '1;
        r_cnt    <= '0;
      end else if (w_accept) begin
        r_q_acc  <= w_q_next;
        r_qm_acc <= w_qm_next;
        r_cnt    <= r_cnt + CW'(1);
        if (w_last) begin
          r_q         <= w_q_next;
          r_res_valid <= 1'b1;
        end
      end
    end
  end

  assign q         = r_q;
  assign res_valid = r_res_valid;

`ifdef OTF_ZERO_DETECT_EN
  logic r_zero;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_zero <= 1'b0;
    else if (w_accept && w_last && !start)  r_zero <= (w_q_next == '0);
  end
  assign zero = r_zero;
`else
  assign zero = 1'b0;
`endif

endmodule
